// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V core types and data-memory arbiter types
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    ARB_NONE,
    ARB_CORE,
    ARB_DBG
  } arb_owner_e;

  typedef struct packed {
    logic            we;
    logic [3:0]      be;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/riscv_rr_arb2.sv
// rtl/riscv_rr_arb2.sv - two-way round-robin grant with its priority pointer register
module riscv_rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  // rr_ptr = 0 favours requester 0 on a tie, 1 favours requester 1
  logic rr_ptr;

  always_comb begin
    gnt_o = 2'b00;
    if (!rst_i) begin
      if (req_i == 2'b11) begin
        gnt_o = rr_ptr ? 2'b10 : 2'b01;
      end else begin
        gnt_o = req_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr <= 1'b0;
    end else if (gnt_o[0]) begin
      rr_ptr <= 1'b1;
    end else if (gnt_o[1]) begin
      rr_ptr <= 1'b0;
    end
  end

endmodule

// File: rtl/riscv_dmem_arbiter.sv
// rtl/riscv_dmem_arbiter.sv - shares single-port data memory between core LSU and debug port
module riscv_dmem_arbiter
  import riscv_pkg::*;
#(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int CNT_W = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            core_req_i,
  input  logic            core_we_i,
  input  logic [3:0]      core_be_i,
  input  logic [XLEN-1:0] core_addr_i,
  input  logic [XLEN-1:0] core_wdata_i,
  output logic            core_gnt_o,
  output logic            core_rvalid_o,
  output logic [XLEN-1:0] core_rdata_o,
  input  logic            dbg_req_i,
  input  logic            dbg_we_i,
  input  logic [3:0]      dbg_be_i,
  input  logic [XLEN-1:0] dbg_addr_i,
  input  logic [XLEN-1:0] dbg_wdata_i,
  output logic            dbg_gnt_o,
  output logic            dbg_rvalid_o,
  output logic [XLEN-1:0] dbg_rdata_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [3:0]      mem_be_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic [XLEN-1:0] mem_rdata_i
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [CNT_W-1:0] core_gnt_cnt_o,
  output logic [CNT_W-1:0] dbg_gnt_cnt_o,
  output logic [CNT_W-1:0] conflict_cnt_o
`endif
);

  typedef struct packed {
    logic            we;
    logic [3:0]      be;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } req_t;

  logic [1:0]      gnt;
  req_t            core_req, dbg_req, mem_cmd;
  arb_owner_e      owner_q;
  logic            owner_we_q;
  logic [XLEN-1:0] resp_data;

  riscv_rr_arb2 u_rr_arb2 (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i ({dbg_req_i, core_req_i}),
    .gnt_o (gnt)
  );

  assign core_gnt_o = gnt[0];
  assign dbg_gnt_o  = gnt[1];

  assign core_req = '{we: core_we_i, be: core_be_i, addr: core_addr_i, wdata: core_wdata_i};
  assign dbg_req  = '{we: dbg_we_i, be: dbg_be_i, addr: dbg_addr_i, wdata: dbg_wdata_i};

  always_comb begin
    mem_cmd = '0;
    if (gnt[0]) begin
      mem_cmd = core_req;
    end else if (gnt[1]) begin
      mem_cmd = dbg_req;
    end
  end

  assign mem_req_o   = |gnt;
  assign mem_we_o    = mem_cmd.we;
  assign mem_be_o    = mem_cmd.be;
  assign mem_addr_o  = mem_cmd.addr;
  assign mem_wdata_o = mem_cmd.wdata;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      owner_q    <= ARB_NONE;
      owner_we_q <= 1'b0;
    end else begin
      owner_q    <= gnt[0] ? ARB_CORE : (gnt[1] ? ARB_DBG : ARB_NONE);
      owner_we_q <= mem_cmd.we;
    end
  end

  assign resp_data     = owner_we_q ? '0 : mem_rdata_i;
  assign core_rvalid_o = (owner_q == ARB_CORE);
  assign dbg_rvalid_o  = (owner_q == ARB_DBG);
  assign core_rdata_o  = core_rvalid_o ? resp_data : '0;
  assign dbg_rdata_o   = dbg_rvalid_o ? resp_data : '0;

`ifdef DMEM_ARB_PERF_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      core_gnt_cnt_o <= '0;
      dbg_gnt_cnt_o  <= '0;
      conflict_cnt_o <= '0;
    end else begin
      if (gnt[0] && (core_gnt_cnt_o != '1)) core_gnt_cnt_o <= core_gnt_cnt_o + CNT_W'(1);
      if (gnt[1] && (dbg_gnt_cnt_o != '1))  dbg_gnt_cnt_o  <= dbg_gnt_cnt_o + CNT_W'(1);
      if (core_req_i && dbg_req_i && (conflict_cnt_o != '1)) begin
        conflict_cnt_o <= conflict_cnt_o + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_riscv_dmem_arbiter.sv
// tb/tb_riscv_dmem_arbiter.sv - self-checking bench for riscv_dmem_arbiter against a behavioural model
module tb_riscv_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req, c_we, d_req, d_we;
  logic [3:0]  c_be, d_be;
  logic [31:0] c_addr, c_wd, d_addr, d_wd;
  logic        core_gnt, core_rvalid, dbg_gnt, dbg_rvalid;
  logic [31:0] core_rdata, dbg_rdata;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;
`ifdef DMEM_ARB_PERF_EN
  logic [3:0]  core_cnt, dbg_cnt, conf_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic        init;
  logic [31:0] env_mem [16];
  logic [31:0] ref_mem [16];

  bit          core_first;
  bit          mg_c, mg_d;
  bit          exp_c_rv, exp_d_rv;
  logic [31:0] exp_c_rd, exp_d_rd;

  always #5 clk = ~clk;

  riscv_dmem_arbiter #(.CNT_W(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .core_req_i(c_req), .core_we_i(c_we), .core_be_i(c_be), .core_addr_i(c_addr),
    .core_wdata_i(c_wd), .core_gnt_o(core_gnt), .core_rvalid_o(core_rvalid), .core_rdata_o(core_rdata),
    .dbg_req_i(d_req), .dbg_we_i(d_we), .dbg_be_i(d_be), .dbg_addr_i(d_addr),
    .dbg_wdata_i(d_wd), .dbg_gnt_o(dbg_gnt), .dbg_rvalid_o(dbg_rvalid), .dbg_rdata_o(dbg_rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
`ifdef DMEM_ARB_PERF_EN
    , .core_gnt_cnt_o(core_cnt), .dbg_gnt_cnt_o(dbg_cnt), .conflict_cnt_o(conf_cnt)
`endif
  );

  function automatic logic [31:0] init_val(input int i);
    if (i == 4) return 32'hDEADBEEF;
    if (i == 2) return 32'h12345678;
    return 32'hA5000000 | (i * 32'h00010203);
  endfunction

  always @(posedge clk) begin
    if (init) begin
      for (int i = 0; i < 16; i++) env_mem[i] <= init_val(i);
    end else if (mem_req) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) env_mem[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= env_mem[mem_addr[5:2]];
      end
    end
  end

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic sample();
    logic [68:0] cmd;
    logic [31:0] old;
    @(negedge clk);
    mg_c = 0;
    mg_d = 0;
    if (!rst) begin
      if (c_req && d_req) begin
        mg_c = core_first;
        mg_d = !core_first;
      end else begin
        mg_c = c_req;
        mg_d = d_req;
      end
    end
    cmd = mg_c ? {c_we, c_be, c_addr, c_wd} : (mg_d ? {d_we, d_be, d_addr, d_wd} : 69'd0);
    if (rst) begin
      exp_c_rv = 0; exp_c_rd = '0; exp_d_rv = 0; exp_d_rd = '0;
    end
    chk("grant", {69'd0, core_gnt, dbg_gnt, mem_req}, {69'd0, mg_c, mg_d, mg_c | mg_d});
    chk("mem_cmd", {3'd0, mem_we, mem_be, mem_addr, mem_wdata}, {3'd0, cmd});
    chk("core_resp", {39'd0, core_rvalid, core_rdata}, {39'd0, exp_c_rv, exp_c_rd});
    chk("dbg_resp", {39'd0, dbg_rvalid, dbg_rdata}, {39'd0, exp_d_rv, exp_d_rd});
    old = ref_mem[cmd[37:34]];
    exp_c_rv = mg_c;
    exp_d_rv = mg_d;
    exp_c_rd = (mg_c && !cmd[68]) ? old : 32'd0;
    exp_d_rd = (mg_d && !cmd[68]) ? old : 32'd0;
    if ((mg_c || mg_d) && cmd[68]) begin
      for (int b = 0; b < 4; b++)
        if (cmd[64 + b]) ref_mem[cmd[37:34]][8*b +: 8] = cmd[8*b +: 8];
    end
    if (rst) core_first = 1;
    else if (mg_c) core_first = 0;
    else if (mg_d) core_first = 1;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    init = 0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
    core_first = 1;
    exp_c_rv = 0; exp_d_rv = 0; exp_c_rd = '0; exp_d_rd = '0;
    init = 1; rst = 1;
    c_req = 1; c_we = 0; c_be = 4'hF; c_addr = 32'h0; c_wd = '0;
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h4; d_wd = '0;

    sample();
    chk("rst_quiet", {67'd0, core_gnt, dbg_gnt, mem_req, core_rvalid, dbg_rvalid}, 72'd0);
    advance();
    rst = 0;

    for (int k = 0; k < 4; k++) begin
      sample();
      chk($sformatf("alt_%0d", k), {70'd0, core_gnt, dbg_gnt}, (k % 2 == 0) ? 72'd2 : 72'd1);
      advance();
    end
    c_req = 0; d_req = 0;

    c_req = 1; c_we = 0; c_addr = 32'h10;
    sample();
    chk("core_rd_gnt", {71'd0, core_gnt}, 72'd1);
    advance();
    c_req = 0;
    sample();
    chk("core_rd_resp", {38'd0, core_rvalid, core_rdata, dbg_rvalid}, {38'd0, 1'b1, 32'hDEADBEEF, 1'b0});
    advance();

    d_req = 1; d_we = 1; d_be = 4'b0001; d_addr = 32'h8; d_wd = 32'h0000_00AA;
    sample();
    chk("dbg_wr_cmd", {67'd0, mem_we, mem_be}, {67'd0, 5'b1_0001});
    advance();
    d_we = 0; d_be = 4'hF;
    sample();
    chk("dbg_wr_resp", {39'd0, dbg_rvalid, dbg_rdata}, {39'd0, 1'b1, 32'd0});
    advance();
    d_req = 0;
    sample();
    chk("dbg_rd_resp", {39'd0, dbg_rvalid, dbg_rdata}, {39'd0, 1'b1, 32'h123456AA});
    advance();

    c_req = 1; c_addr = 32'h10;
    sample();
    chk("rst_mid_gnt", {71'd0, core_gnt}, 72'd1);
    advance();
    rst = 1; c_req = 0;
    sample();
    chk("rst_mid_drop", {71'd0, core_rvalid}, 72'd0);
    advance();
    rst = 0; c_req = 1; d_req = 1;
    sample();
    chk("rst_ptr_core", {70'd0, core_gnt, dbg_gnt}, 72'd2);
    advance();
    c_req = 0; d_req = 0;

`ifdef DMEM_ARB_PERF_EN
    rst = 1;
    sample();
    advance();
    rst = 0; c_req = 1; d_req = 1;
    for (int i = 0; i < 40; i++) begin
      sample();
      if (i == 10) chk("perf_10", {60'd0, conf_cnt, core_cnt, dbg_cnt}, {60'd0, 4'd10, 4'd5, 4'd5});
      advance();
    end
    c_req = 0; d_req = 0;
    sample();
    chk("perf_sat", {60'd0, conf_cnt, core_cnt, dbg_cnt}, {60'd0, 12'hFFF});
    advance();
`endif

    for (int n = 0; n < 3000; n++) begin
      sample();
      @(posedge clk);
      #1;
      if (mg_c) c_req = 0;
      if (mg_d) d_req = 0;
      rst = ($urandom_range(0, 299) == 0);
      if (!c_req && $urandom_range(0, 3) != 0) begin
        c_req = 1; c_we = $urandom_range(0, 1); c_be = 4'($urandom);
        c_addr = 32'($urandom_range(0, 63)); c_wd = $urandom;
      end
      if (!d_req && $urandom_range(0, 3) != 0) begin
        d_req = 1; d_we = $urandom_range(0, 1); d_be = 4'($urandom);
        d_addr = 32'($urandom_range(0, 63)); d_wd = $urandom;
      end
    end
    sample();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
